fetch_unit: RTL and testbench

Instruction-fetch stage of the MINI-RISC pipeline, directly upstream of the F/D pipeline register. It owns the 11-bit program counter and drives the instruction-memory address. It presents `instruction_F` / `pc_F` to the F/D register and raises `flush_F` on taken branches. A small state machine sequences boot, normal fetch and halt.

---
 rtl/fetch_if.sv | 21 ++
 rtl/fetch_unit.sv | 43 ++++
 tb/tb_fetch_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: fetch-stage bus bundle between fetch_unit and its imem / F-D / hazard neighbours
interface fetch_if;
  logic        stall_F;
  logic        branch_taken_E;
  logic [10:0] branch_target_E;
  logic [10:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instruction_F;
  logic [10:0] pc_F;
  logic        flush_F;
  logic        halted;
  logic [15:0] fetch_count;
  modport master(
    input  stall_F, branch_taken_E, branch_target_E, imem_data,
    output imem_addr, instruction_F, pc_F, flush_F, halted, fetch_count
  );
  modport slave(
    output stall_F, branch_taken_E, branch_target_E, imem_data,
    input  imem_addr, instruction_F, pc_F, flush_F, halted, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MINI-RISC fetch stage owning the PC, boot/run/halt sequencing and a saturating issue counter
module fetch_unit #(
  parameter logic [10:0] RESET_PC    = 11'h000,
  parameter logic [4:0]  HALT_OPCODE = 5'b11111
) (
  input  logic  clk,
  input  logic  reset,
  fetch_if.master bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  state_t      r_state, w_state;
  logic [10:0] r_pc, w_pc;
  logic [15:0] r_cnt, w_cnt;
  logic        w_issue, w_hlt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_cnt   <= 16'h0000;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_cnt   <= w_cnt;
    end
  end
  // a redirect outranks everything, including BOOT and a wrong-path HLT
  always_comb begin
    w_issue = r_state == RUN && !bus.stall_F && !bus.branch_taken_E;
    w_hlt   = bus.imem_data[15:11] == HALT_OPCODE;
    w_state = bus.branch_taken_E ? RUN :
              r_state == BOOT    ? RUN :
              w_issue && w_hlt   ? HALTED : r_state;
    w_pc    = bus.branch_taken_E ? bus.branch_target_E :
              w_issue && !w_hlt  ? r_pc + 11'd1 : r_pc;
    w_cnt   = w_issue && r_cnt != 16'hFFFF ? r_cnt + 16'd1 : r_cnt;
  end
  assign bus.imem_addr     = r_pc;
  assign bus.pc_F          = r_pc;
  assign bus.instruction_F = r_state == RUN ? bus.imem_data : 16'h0000;
  assign bus.flush_F       = bus.branch_taken_E;
  assign bus.halted        = r_state == HALTED;
  assign bus.fetch_count   = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle vectors plus hand sequences for reset, boot redirect and counter saturation
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic hlt_en = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  fetch_if bus();
  fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_data = (hlt_en && bus.imem_addr == 11'd4) ? 16'hF800 : {5'b00001, bus.imem_addr};
  typedef struct {
    logic        st;
    logic        br;
    logic [10:0] tg;
    logic [10:0] pc;
    logic [15:0] ins;
    logic        fl;
    logic        h;
    logic [15:0] c;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " pc_F"}, 32'(bus.pc_F), 32'(v.pc));
    chk({tag, " instruction_F"}, 32'(bus.instruction_F), 32'(v.ins));
    chk({tag, " flush_F"}, 32'(bus.flush_F), 32'(v.fl));
    chk({tag, " halted"}, 32'(bus.halted), 32'(v.h));
    chk({tag, " fetch_count"}, 32'(bus.fetch_count), 32'(v.c));
  endtask
  initial begin
    bus.stall_F = 1'b0;
    bus.branch_taken_E = 1'b0;
    bus.branch_target_E = 11'h000;
    //          st br tg      pc      ins       fl h  c
    vq.push_back('{0, 0, 11'h000, 11'h000, 16'h0000, 0, 0, 16'd0});
    vq.push_back('{0, 0, 11'h000, 11'h000, 16'h0800, 0, 0, 16'd0});
    vq.push_back('{0, 0, 11'h000, 11'h001, 16'h0801, 0, 0, 16'd1});
    vq.push_back('{0, 0, 11'h000, 11'h002, 16'h0802, 0, 0, 16'd2});
    vq.push_back('{0, 0, 11'h000, 11'h003, 16'h0803, 0, 0, 16'd3});
    vq.push_back('{1, 0, 11'h000, 11'h004, 16'hF800, 0, 0, 16'd4});
    vq.push_back('{1, 0, 11'h000, 11'h004, 16'hF800, 0, 0, 16'd4});
    vq.push_back('{0, 0, 11'h000, 11'h004, 16'hF800, 0, 0, 16'd4});
    vq.push_back('{0, 0, 11'h000, 11'h004, 16'h0000, 0, 1, 16'd5});
    vq.push_back('{1, 0, 11'h000, 11'h004, 16'h0000, 0, 1, 16'd5});
    vq.push_back('{0, 1, 11'h020, 11'h004, 16'h0000, 1, 1, 16'd5});
    vq.push_back('{0, 0, 11'h000, 11'h020, 16'h0820, 0, 0, 16'd5});
    vq.push_back('{0, 1, 11'h005, 11'h021, 16'h0821, 1, 0, 16'd6});
    vq.push_back('{1, 0, 11'h000, 11'h005, 16'h0805, 0, 0, 16'd6});
    vq.push_back('{1, 0, 11'h000, 11'h005, 16'h0805, 0, 0, 16'd6});
    vq.push_back('{1, 0, 11'h000, 11'h005, 16'h0805, 0, 0, 16'd6});
    vq.push_back('{0, 0, 11'h000, 11'h005, 16'h0805, 0, 0, 16'd6});
    vq.push_back('{0, 0, 11'h000, 11'h006, 16'h0806, 0, 0, 16'd7});
    vq.push_back('{0, 0, 11'h000, 11'h007, 16'h0807, 0, 0, 16'd8});
    vq.push_back('{0, 0, 11'h000, 11'h008, 16'h0808, 0, 0, 16'd9});
    vq.push_back('{0, 0, 11'h000, 11'h009, 16'h0809, 0, 0, 16'd10});
    vq.push_back('{1, 1, 11'h200, 11'h00A, 16'h080A, 1, 0, 16'd11});
    vq.push_back('{0, 1, 11'h7FF, 11'h200, 16'h0A00, 1, 0, 16'd11});
    vq.push_back('{0, 0, 11'h000, 11'h7FF, 16'h0FFF, 0, 0, 16'd11});
    vq.push_back('{0, 0, 11'h000, 11'h000, 16'h0800, 0, 0, 16'd12});
    vq.push_back('{0, 1, 11'h004, 11'h001, 16'h0801, 1, 0, 16'd13});
    vq.push_back('{0, 1, 11'h030, 11'h004, 16'hF800, 1, 0, 16'd13});
    vq.push_back('{0, 0, 11'h000, 11'h030, 16'h0830, 0, 0, 16'd13});
    vq.push_back('{0, 0, 11'h000, 11'h031, 16'h0831, 0, 0, 16'd14});
    // asynchronous reset before any clock edge
    #3 reset = 1'b1;
    #1;
    chk("por pc_F", 32'(bus.pc_F), 32'h0);
    chk("por instruction_F", 32'(bus.instruction_F), 32'h0);
    chk("por fetch_count", 32'(bus.fetch_count), 32'h0);
    chk("por halted", 32'(bus.halted), 32'h0);
    step();
    step();
    reset = 1'b0;
    foreach (vq[i]) begin
      bus.stall_F = vq[i].st;
      bus.branch_taken_E = vq[i].br;
      bus.branch_target_E = vq[i].tg;
      #1;
      chk_all($sformatf("vec%0d", i), vq[i]);
      step();
    end
    bus.stall_F = 1'b0;
    bus.branch_taken_E = 1'b0;
    // HALTED must hold for many cycles
    bus.branch_target_E = 11'h004;
    bus.branch_taken_E = 1'b1;
    step();
    bus.branch_taken_E = 1'b0;
    step();
    for (int i = 0; i < 10; i++) step();
    chk("halt hold halted", 32'(bus.halted), 32'h1);
    chk("halt hold pc_F", 32'(bus.pc_F), 32'h004);
    chk("halt hold fetch_count", 32'(bus.fetch_count), 32'd16);
    chk("halt hold instruction_F", 32'(bus.instruction_F), 32'h0);
    bus.branch_target_E = 11'h020;
    bus.branch_taken_E = 1'b1;
    step();
    bus.branch_taken_E = 1'b0;
    #1;
    chk("halt exit halted", 32'(bus.halted), 32'h0);
    chk("halt exit pc_F", 32'(bus.pc_F), 32'h020);
    // asynchronous reset in the middle of RUN
    step();
    #1 reset = 1'b1;
    #1;
    chk("midrst pc_F", 32'(bus.pc_F), 32'h0);
    chk("midrst instruction_F", 32'(bus.instruction_F), 32'h0);
    chk("midrst fetch_count", 32'(bus.fetch_count), 32'h0);
    chk("midrst halted", 32'(bus.halted), 32'h0);
    step();
    reset = 1'b0;
    // redirect during BOOT overrides the boot cycle
    bus.branch_target_E = 11'h100;
    bus.branch_taken_E = 1'b1;
    #1;
    chk("boot br flush_F", 32'(bus.flush_F), 32'h1);
    chk("boot br instruction_F", 32'(bus.instruction_F), 32'h0);
    step();
    bus.branch_taken_E = 1'b0;
    #1;
    chk("boot br pc_F", 32'(bus.pc_F), 32'h100);
    chk("boot br instruction_F run", 32'(bus.instruction_F), 32'h0900);
    chk("boot br fetch_count", 32'(bus.fetch_count), 32'h0);
    step();
    chk("boot br next pc_F", 32'(bus.pc_F), 32'h101);
    chk("boot br next fetch_count", 32'(bus.fetch_count), 32'h1);
    // saturation: run issues until the counter tops out
    hlt_en = 1'b0;
    begin
      int k = 0;
      while (bus.fetch_count != 16'hFFFF && k < 70000) begin
        step();
        k++;
      end
      chk("sat reached", 32'(bus.fetch_count), 32'hFFFF);
    end
    for (int i = 0; i < 3; i++) step();
    begin
      logic [10:0] p0;
      p0 = bus.pc_F;
      step();
      chk("sat hold fetch_count", 32'(bus.fetch_count), 32'hFFFF);
      chk("sat pc advances", 32'(bus.pc_F), 32'(p0 + 11'd1));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
